alu_exec_seq: RTL and testbench

Execute-stage sequencer that sits directly upstream of the ALU and owns the working register W and the status register.
- Accepts one instruction at a time through a valid/ready handshake.
- For W,P opcodes, fetches operand P from synchronous data memory.
- Drives the combinational ALU, then writes the ALU result to W and the ALU status to the status register.
- Signals completion with a one-cycle done pulse.

---
 rtl/alu_exec_seq.sv | 142 ++++++++++++++
 tb/tb_alu_exec_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_seq.sv
// Execute-stage sequencer: owns W and the status register, fetches memory operands
// and drives the external combinational ALU, one instruction at a time.
module alu_exec_seq #(
   parameter int         ADDR_W = 8,
   parameter logic [7:0] W_INIT = 8'h00
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [3:0]        i_opcode,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_wld,
   input  logic [7:0]        i_wld_data,
   output logic              o_mem_rd,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic [7:0]        i_mem_rdata,
   output logic [3:0]        o_alu_opcode,
   output logic [7:0]        o_alu_oper1,
   output logic [7:0]        o_alu_oper2,
   input  logic [7:0]        i_alu_res,
   input  logic [2:0]        i_alu_status,
   output logic [7:0]        o_w,
   output logic [2:0]        o_status,
   output logic              o_done,
   output logic              o_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_MEMW,
      S_EXEC
   } state_e;

   // Binary (W,P) opcodes occupy the contiguous range ANDWP..SHFRW.
   localparam logic [3:0] OP_ANDWP = 4'd5;
   localparam logic [3:0] OP_CMPWP = 4'd10;
   localparam logic [3:0] OP_SHFRW = 4'd12;

   state_e              state_q,  state_d;
   logic [7:0]          w_q,      w_d;
   logic [2:0]          status_q, status_d;
   logic [7:0]          oper_q,   oper_d;
   logic [3:0]          opcode_q, opcode_d;
   logic [ADDR_W-1:0]   addr_q,   addr_d;
   logic                mem_rd_q, mem_rd_d;
   logic                done_q,   done_d;
   logic                err_q,    err_d;

   logic in_is_binary;
   logic op_is_legal;

   assign in_is_binary = (i_opcode >= OP_ANDWP) && (i_opcode <= OP_SHFRW);
   assign op_is_legal  = (opcode_q <= OP_SHFRW);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      w_d      = w_q;
      status_d = status_q;
      oper_d   = oper_q;
      opcode_d = opcode_q;
      addr_d   = addr_q;
      mem_rd_d = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               opcode_d = i_opcode;
               addr_d   = i_addr;
               if (in_is_binary) begin
                  state_d  = S_FETCH;
                  mem_rd_d = 1'b1;
               end else begin
                  state_d = S_EXEC;
                  oper_d  = 8'h00;
               end
            end else if (i_wld) begin
               w_d = i_wld_data;
            end
         end
         S_FETCH: state_d = S_MEMW;
         S_MEMW: begin
            oper_d  = i_mem_rdata;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (op_is_legal) begin
               status_d = i_alu_status;
               if (opcode_q != OP_CMPWP) w_d = i_alu_res;
            end else begin
               err_d = 1'b1;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // the pre-edge values, independent of statement order.
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         w_q      <= W_INIT;
         status_q <= 3'b000;
         oper_q   <= 8'h00;
         opcode_q <= 4'h0;
         addr_q   <= '0;
         mem_rd_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         w_q      <= w_d;
         status_q <= status_d;
         oper_q   <= oper_d;
         opcode_q <= opcode_d;
         addr_q   <= addr_d;
         mem_rd_q <= mem_rd_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign o_ready      = (state_q == S_IDLE);
   assign o_mem_rd     = mem_rd_q;
   assign o_mem_addr   = addr_q;
   assign o_alu_opcode = opcode_q;
   assign o_alu_oper1  = w_q;
   assign o_alu_oper2  = oper_q;
   assign o_w          = w_q;
   assign o_status     = status_q;
   assign o_done       = done_q;
   assign o_err        = err_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Bench for alu_exec_seq: stand-in ALU and synchronous memory, a vector table for
// single instructions, and hand-written sequences for the multi-cycle corners.
module tb_alu_exec_seq;

   localparam int         ADDR_W = 8;
   localparam logic [7:0] W_INIT = 8'h3C;

   localparam logic [3:0] ZEROW = 4'd0,  BNOTW = 4'd1,  NEGTW = 4'd2,  INCRW = 4'd3;
   localparam logic [3:0] DECRW = 4'd4,  ANDWP = 4'd5,  IORWP = 4'd6,  XORWP = 4'd7;
   localparam logic [3:0] ADDWP = 4'd8,  SUBWP = 4'd9,  CMPWP = 4'd10, SHFLW = 4'd11;
   localparam logic [3:0] SHFRW = 4'd12;

   logic              i_clk;
   logic              i_rst_n;
   logic              i_valid;
   logic              o_ready;
   logic [3:0]        i_opcode;
   logic [ADDR_W-1:0] i_addr;
   logic              i_wld;
   logic [7:0]        i_wld_data;
   logic              o_mem_rd;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [7:0]        i_mem_rdata;
   logic [3:0]        o_alu_opcode;
   logic [7:0]        o_alu_oper1;
   logic [7:0]        o_alu_oper2;
   logic [7:0]        i_alu_res;
   logic [2:0]        i_alu_status;
   logic [7:0]        o_w;
   logic [2:0]        o_status;
   logic              o_done;
   logic              o_err;

   alu_exec_seq #(.ADDR_W(ADDR_W), .W_INIT(W_INIT)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_opcode     (i_opcode),
      .i_addr       (i_addr),
      .i_wld        (i_wld),
      .i_wld_data   (i_wld_data),
      .o_mem_rd     (o_mem_rd),
      .o_mem_addr   (o_mem_addr),
      .i_mem_rdata  (i_mem_rdata),
      .o_alu_opcode (o_alu_opcode),
      .o_alu_oper1  (o_alu_oper1),
      .o_alu_oper2  (o_alu_oper2),
      .i_alu_res    (i_alu_res),
      .i_alu_status (i_alu_status),
      .o_w          (o_w),
      .o_status     (o_status),
      .o_done       (o_done),
      .o_err        (o_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Synchronous data memory: read data valid the cycle after the strobe.
   logic [7:0] mem [256];
   always @(posedge i_clk) if (o_mem_rd) i_mem_rdata <= mem[o_mem_addr];

   // Stand-in ALU: Z = result zero, N = result bit 7, C = carry out of ADDWP only.
   logic [8:0] alu_sum;
   always_comb begin
      alu_sum   = 9'd0;
      i_alu_res = 8'h00;
      case (o_alu_opcode)
         ZEROW: i_alu_res = 8'h00;
         BNOTW: i_alu_res = ~o_alu_oper1;
         NEGTW: i_alu_res = 8'h00 - o_alu_oper1;
         INCRW: i_alu_res = o_alu_oper1 + 8'd1;
         DECRW: i_alu_res = o_alu_oper1 - 8'd1;
         ANDWP: i_alu_res = o_alu_oper1 & o_alu_oper2;
         IORWP: i_alu_res = o_alu_oper1 | o_alu_oper2;
         XORWP: i_alu_res = o_alu_oper1 ^ o_alu_oper2;
         ADDWP: begin
            alu_sum   = {1'b0, o_alu_oper1} + {1'b0, o_alu_oper2};
            i_alu_res = alu_sum[7:0];
         end
         SUBWP, CMPWP: i_alu_res = o_alu_oper1 - o_alu_oper2;
         SHFLW: i_alu_res = o_alu_oper1 << o_alu_oper2[2:0];
         SHFRW: i_alu_res = o_alu_oper1 >> o_alu_oper2[2:0];
         default: i_alu_res = 8'hEE;
      endcase
      i_alu_status = {alu_sum[8], i_alu_res[7], (i_alu_res == 8'h00)};
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic load_w(input logic [7:0] v);
      @(negedge i_clk);
      i_wld = 1'b1; i_wld_data = v;
      @(negedge i_clk);
      i_wld = 1'b0;
      check("wld_w", {24'd0, o_w}, {24'd0, v});
   endtask

   // Issues one instruction (now=1: in the current cycle) and watches up to 8 cycles
   // for o_done while scrambling inputs that must be ignored mid-instruction.
   task automatic issue(input logic [3:0] op, input logic [7:0] addr, input bit now,
                        output int lat, output logic err, output int rd_cnt,
                        output int rd_cyc, output logic [7:0] rd_addr);
      if (!now) @(negedge i_clk);
      check("ready_at_issue", {31'd0, o_ready}, 32'd1);
      i_valid = 1'b1; i_opcode = op; i_addr = addr;
      @(negedge i_clk);
      i_valid = 1'b0; i_opcode = ~op; i_addr = ~addr;
      i_wld = 1'b1; i_wld_data = 8'hA5;
      lat = -1; err = 1'b0; rd_cnt = 0; rd_cyc = -1; rd_addr = 8'h00;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         if (o_mem_rd) begin
            rd_cnt++; rd_cyc = cyc; rd_addr = o_mem_addr;
         end
         if (o_done) begin
            lat = cyc; err = o_err;
            break;
         end
         @(negedge i_clk);
      end
      i_wld = 1'b0;
   endtask

   typedef struct {
      string      name;
      logic [3:0] op;
      logic [7:0] addr;
      logic [7:0] w0;
      logic [7:0] memv;
      logic [7:0] exp_w;
      logic [2:0] exp_st;
      int         exp_lat;
   } vec_t;

   vec_t vecs[14];

   int         lat, rd_cnt, rd_cyc, n_done;
   logic       err;
   logic [7:0] rd_addr;

   initial begin
      vecs[0]  = '{"addwp",      ADDWP, 8'h10, 8'd33,  8'd44,  8'd77,  3'b000, 4};
      vecs[1]  = '{"incrw_wrap", INCRW, 8'h00, 8'd255, 8'd0,   8'd0,   3'b001, 2};
      vecs[2]  = '{"cmpwp_lt",   CMPWP, 8'h11, 8'd80,  8'd90,  8'd80,  3'b010, 4};
      vecs[3]  = '{"cmpwp_eq",   CMPWP, 8'h12, 8'd80,  8'd80,  8'd80,  3'b001, 4};
      vecs[4]  = '{"shflw",      SHFLW, 8'h13, 8'hCC,  8'd3,   8'h60,  3'b000, 4};
      vecs[5]  = '{"subwp",      SUBWP, 8'h14, 8'd50,  8'd20,  8'd30,  3'b000, 4};
      vecs[6]  = '{"andwp",      ANDWP, 8'h15, 8'hF0,  8'h3C,  8'h30,  3'b000, 4};
      vecs[7]  = '{"xorwp_zero", XORWP, 8'h16, 8'hAA,  8'hAA,  8'h00,  3'b001, 4};
      vecs[8]  = '{"iorwp",      IORWP, 8'h17, 8'h0F,  8'h80,  8'h8F,  3'b010, 4};
      vecs[9]  = '{"negtw",      NEGTW, 8'h00, 8'h01,  8'd0,   8'hFF,  3'b010, 2};
      vecs[10] = '{"bnotw",      BNOTW, 8'h00, 8'h0F,  8'd0,   8'hF0,  3'b010, 2};
      vecs[11] = '{"zerow",      ZEROW, 8'h00, 8'h77,  8'd0,   8'h00,  3'b001, 2};
      vecs[12] = '{"addwp_cy",   ADDWP, 8'hFE, 8'hC8,  8'h64,  8'h2C,  3'b100, 4};
      vecs[13] = '{"shfrw",      SHFRW, 8'h18, 8'h80,  8'd7,   8'h01,  3'b000, 4};

      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      i_rst_n = 1'b0; i_valid = 1'b0; i_opcode = 4'h0; i_addr = 8'h00;
      i_wld = 1'b0; i_wld_data = 8'h00;

      // Reset state
      @(negedge i_clk);
      @(negedge i_clk);
      check("rst_w",      {24'd0, o_w},       {24'd0, W_INIT});
      check("rst_status", {29'd0, o_status},  32'd0);
      check("rst_ready",  {31'd0, o_ready},   32'd1);
      check("rst_done",   {31'd0, o_done},    32'd0);
      check("rst_err",    {31'd0, o_err},     32'd0);
      check("rst_mem_rd", {31'd0, o_mem_rd},  32'd0);
      check("rst_oper2",  {24'd0, o_alu_oper2}, 32'd0);
      check("rst_addr",   {24'd0, o_mem_addr},  32'd0);
      i_rst_n = 1'b1;

      // Single-instruction vectors
      foreach (vecs[i]) begin
         mem[vecs[i].addr] = vecs[i].memv;
         load_w(vecs[i].w0);
         issue(vecs[i].op, vecs[i].addr, 1'b0, lat, err, rd_cnt, rd_cyc, rd_addr);
         check({vecs[i].name, "_lat"},    lat, vecs[i].exp_lat);
         check({vecs[i].name, "_w"},      {24'd0, o_w},      {24'd0, vecs[i].exp_w});
         check({vecs[i].name, "_status"}, {29'd0, o_status}, {29'd0, vecs[i].exp_st});
         check({vecs[i].name, "_err"},    {31'd0, err},      32'd0);
         if (vecs[i].exp_lat == 4) begin
            check({vecs[i].name, "_rd_cnt"},  rd_cnt, 1);
            check({vecs[i].name, "_rd_cyc"},  rd_cyc, 1);
            check({vecs[i].name, "_rd_addr"}, {24'd0, rd_addr}, {24'd0, vecs[i].addr});
         end else begin
            check({vecs[i].name, "_rd_cnt"},  rd_cnt, 0);
         end
      end

      // Back-to-back: DECRW accepted in the INCRW done cycle
      load_w(8'd255);
      issue(INCRW, 8'h00, 1'b0, lat, err, rd_cnt, rd_cyc, rd_addr);
      check("b2b_inc_lat",    lat, 2);
      check("b2b_inc_w",      {24'd0, o_w},      32'd0);
      check("b2b_inc_status", {29'd0, o_status}, 32'b001);
      issue(DECRW, 8'h00, 1'b1, lat, err, rd_cnt, rd_cyc, rd_addr);
      check("b2b_dec_lat",    lat, 2);
      check("b2b_dec_w",      {24'd0, o_w},      32'd255);
      check("b2b_dec_status", {29'd0, o_status}, 32'b010);

      // Illegal opcode: status primed to 3'b100 via a carrying add, then W reloaded
      mem[8'h40] = 8'd100;
      load_w(8'd200);
      issue(ADDWP, 8'h40, 1'b0, lat, err, rd_cnt, rd_cyc, rd_addr);
      check("ill_prime_status", {29'd0, o_status}, 32'b100);
      load_w(8'h5A);
      issue(4'hE, 8'h00, 1'b0, lat, err, rd_cnt, rd_cyc, rd_addr);
      check("ill_lat",    lat, 2);
      check("ill_err",    {31'd0, err},      32'd1);
      check("ill_rd_cnt", rd_cnt, 0);
      check("ill_w",      {24'd0, o_w},      32'h5A);
      check("ill_status", {29'd0, o_status}, 32'b100);
      @(negedge i_clk);
      check("ill_done_1cyc", {30'd0, o_done, o_err}, 32'd0);

      // Reset asserted while in MEMW abandons the instruction
      mem[8'h50] = 8'd100;
      load_w(8'd200);
      @(negedge i_clk);
      i_valid = 1'b1; i_opcode = ADDWP; i_addr = 8'h50;
      @(negedge i_clk);
      i_valid = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      check("mrst_done",   {31'd0, o_done},   32'd0);
      check("mrst_w",      {24'd0, o_w},      {24'd0, W_INIT});
      check("mrst_status", {29'd0, o_status}, 32'd0);
      check("mrst_ready",  {31'd0, o_ready},  32'd1);
      n_done = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge i_clk);
         if (o_done) n_done++;
      end
      check("mrst_no_done", n_done, 0);
      check("mrst_w_hold",  {24'd0, o_w}, {24'd0, W_INIT});

      // Valid and direct load in the same IDLE cycle: the instruction wins
      mem[8'h60] = 8'd3;
      load_w(8'b1100_1100);
      @(negedge i_clk);
      i_valid = 1'b1; i_opcode = SHFLW; i_addr = 8'h60;
      i_wld = 1'b1; i_wld_data = 8'h55;
      @(negedge i_clk);
      i_valid = 1'b0; i_wld = 1'b0;
      check("coll_w_not_loaded", {24'd0, o_w}, 32'hCC);
      lat = -1;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         if (o_done) begin
            lat = cyc;
            break;
         end
         @(negedge i_clk);
      end
      check("coll_lat",    lat, 4);
      check("coll_w",      {24'd0, o_w},      32'b0110_0000);
      check("coll_status", {29'd0, o_status}, 32'b000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
